dispensador_multi: RTL and testbench

- Parametrised successor to the single-product vending controller: NPROD products with individual prices, credit built from 1/2/5-peso coin pulses, buy/cancel commands, inactivity timeout refund, and change paid out one peso per second.
- Sits between the button debouncers / 1 s tick divider and the display multiplexer. Its credit and change values feed the 7-segment path; one-hot dispense lines drive the product LEDs.

---
 rtl/dispensador_multi_pkg.sv | 24 ++
 rtl/dispensador_multi_contador_seg.sv | 36 +++
 rtl/dispensador_multi.sv | 196 +++++++++++++++++++
 tb/tb_dispensador_multi.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dispensador_multi_pkg.sv
// Shared types and constants for the multi-product vending controller.
package dispensador_multi_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    CREDITO  = 2'd1,
    DISPENSA = 2'd2,
    CAMBIO   = 2'd3
  } estado_t;

  localparam int unsigned VAL_MON_1 = 1;
  localparam int unsigned VAL_MON_2 = 2;
  localparam int unsigned VAL_MON_5 = 5;

  // Price tables are passed zero-extended to 64 bits (up to 8 products x 8 bits).
  function automatic int unsigned precio_de(input logic [63:0] tabla,
                                            input int unsigned idx,
                                            input int unsigned ancho);
    logic [63:0] campo;
    campo = (tabla >> (idx * ancho)) & ((64'd1 << ancho) - 64'd1);
    return campo[31:0];
  endfunction

endpackage

// File: rtl/dispensador_multi_contador_seg.sv
// Loadable seconds down-counter; done flags the tick that takes it from 1 to 0.
module contador_seg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reseteo,
  input  logic         tick,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] valor,
  output logic         done
);

  logic [W-1:0] cuenta_q, cuenta_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cuenta_d = cuenta_q;
    if (clr) begin
      cuenta_d = '0;
    end else if (load) begin
      cuenta_d = valor;
    end else if (tick && cuenta_q != '0) begin
      cuenta_d = cuenta_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (!reseteo) cuenta_q <= '0;
    else          cuenta_q <= cuenta_d;
  end

  assign done = tick && (cuenta_q == W'(1));

endmodule

// File: rtl/dispensador_multi.sv
// Multi-product vending controller: coin credit, buy/cancel, idle refund, paced change payout.
module dispensador_multi
  import dispensador_multi_pkg::*;
#(
  parameter int NPROD     = 4,
  parameter int CRED_W    = 6,
  parameter int MAX_CRED  = 45,
  parameter logic [NPROD*CRED_W-1:0] PRICES = {6'd5, 6'd7, 6'd9, 6'd12},
  parameter int TIMEOUT_S = 10,
  parameter int DISP_S    = 2
) (
  input  logic                     clock,
  input  logic                     reseteo,
  input  logic                     tick_1s,
  input  logic                     mon_1,
  input  logic                     mon_2,
  input  logic                     mon_5,
  input  logic [$clog2(NPROD)-1:0] sel,
  input  logic                     comprar,
  input  logic                     cancelar,
  output logic [CRED_W-1:0]        credito,
  output logic [CRED_W-1:0]        cambio,
  output logic [NPROD-1:0]         dispensa,
  output logic                     rechazo,
  output logic                     insuf,
  output logic [1:0]               estado
);

  localparam int T_W   = $clog2(TIMEOUT_S + 1);
  localparam int D_W   = $clog2(DISP_S + 1);
  localparam int TD_W  = (T_W > D_W) ? T_W : D_W;
  localparam int CNT_W = (TD_W > CRED_W) ? TD_W : CRED_W;

  estado_t             estado_q, estado_d;
  logic [CRED_W-1:0]   credito_q, credito_d;
  logic [CRED_W-1:0]   cambio_q, cambio_d;
  logic [NPROD-1:0]    dispensa_q, dispensa_d;
  logic                rechazo_q, rechazo_d;
  logic                insuf_q, insuf_d;

  logic                cnt_clr, cnt_load, cnt_done;
  logic [CNT_W-1:0]    cnt_valor;

  logic [CRED_W-1:0]   mon_val, precio;
  logic                mon_any, mon_drop, cabe, sel_ok;
  logic [CRED_W:0]     suma;

  contador_seg #(.W(CNT_W)) u_contador (
    .clock   (clock),
    .reseteo (reseteo),
    .tick    (tick_1s),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .valor   (cnt_valor),
    .done    (cnt_done)
  );

  // Coin decode: 5 beats 2 beats 1; every losing coin is reported as refused.
  always_comb begin
    mon_val  = '0;
    mon_drop = 1'b0;
    if (mon_5) begin
      mon_val  = CRED_W'(VAL_MON_5);
      mon_drop = mon_2 | mon_1;
    end else if (mon_2) begin
      mon_val  = CRED_W'(VAL_MON_2);
      mon_drop = mon_1;
    end else if (mon_1) begin
      mon_val  = CRED_W'(VAL_MON_1);
    end
  end

  assign mon_any = mon_1 | mon_2 | mon_5;
  assign suma    = {1'b0, credito_q} + {1'b0, mon_val};
  assign cabe    = suma <= (CRED_W+1)'(MAX_CRED);
  assign sel_ok  = 32'(sel) < NPROD;
  assign precio  = CRED_W'(precio_de(64'(PRICES), 32'(sel), CRED_W));

  always_comb begin
    estado_d   = estado_q;
    credito_d  = credito_q;
    cambio_d   = cambio_q;
    dispensa_d = dispensa_q;
    rechazo_d  = 1'b0;
    insuf_d    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_valor  = '0;

    case (estado_q)
      REPOSO: begin
        cnt_clr = 1'b1;
        if (mon_any) begin
          rechazo_d = mon_drop | ~cabe;
          if (cabe) begin
            credito_d = suma[CRED_W-1:0];
            estado_d  = CREDITO;
            cnt_clr   = 1'b0;
            cnt_load  = 1'b1;
            cnt_valor = CNT_W'(TIMEOUT_S);
          end
        end
      end

      CREDITO: begin
        if (cancelar) begin
          rechazo_d = mon_any;
          cambio_d  = credito_q;
          credito_d = '0;
          estado_d  = CAMBIO;
          cnt_load  = 1'b1;
          cnt_valor = CNT_W'(credito_q);
        end else if (comprar) begin
          rechazo_d = mon_any;
          cnt_load  = 1'b1;
          cnt_valor = CNT_W'(TIMEOUT_S);
          if (sel_ok && credito_q >= precio) begin
            cambio_d   = credito_q - precio;
            credito_d  = '0;
            dispensa_d = NPROD'(1) << sel;
            estado_d   = DISPENSA;
            cnt_valor  = CNT_W'(DISP_S);
          end else begin
            insuf_d = 1'b1;
          end
        end else if (mon_any && cabe) begin
          rechazo_d = mon_drop;
          credito_d = suma[CRED_W-1:0];
          cnt_load  = 1'b1;
          cnt_valor = CNT_W'(TIMEOUT_S);
        end else begin
          // Only an over-limit coin can reach here; it does not count as activity.
          rechazo_d = mon_any;
          if (cnt_done) begin
            cambio_d  = credito_q;
            credito_d = '0;
            estado_d  = CAMBIO;
            cnt_load  = 1'b1;
            cnt_valor = CNT_W'(credito_q);
          end
        end
      end

      DISPENSA: begin
        rechazo_d = mon_any;
        if (cnt_done) begin
          dispensa_d = '0;
          if (cambio_q != '0) begin
            estado_d  = CAMBIO;
            cnt_load  = 1'b1;
            cnt_valor = CNT_W'(cambio_q);
          end else begin
            estado_d = REPOSO;
          end
        end
      end

      CAMBIO: begin
        rechazo_d = mon_any;
        if (tick_1s && cambio_q != '0) cambio_d = cambio_q - CRED_W'(1);
        if (cnt_done) begin
          cambio_d = '0;
          estado_d = REPOSO;
        end
      end

      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reseteo) begin
      estado_q   <= REPOSO;
      credito_q  <= '0;
      cambio_q   <= '0;
      dispensa_q <= '0;
      rechazo_q  <= 1'b0;
      insuf_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      credito_q  <= credito_d;
      cambio_q   <= cambio_d;
      dispensa_q <= dispensa_d;
      rechazo_q  <= rechazo_d;
      insuf_q    <= insuf_d;
    end
  end

  assign credito  = credito_q;
  assign cambio   = cambio_q;
  assign dispensa = dispensa_q;
  assign rechazo  = rechazo_q;
  assign insuf    = insuf_q;
  assign estado   = estado_q;

endmodule

// File: tb/tb_dispensador_multi.sv
// Scoreboard bench for dispensador_multi: expected outputs queued per driven cycle, popped after the edge.
module tb_dispensador_multi;

  localparam logic [2:0] N  = 3'b000;
  localparam logic [2:0] M1 = 3'b001;
  localparam logic [2:0] M2 = 3'b010;
  localparam logic [2:0] M5 = 3'b100;

  logic       clock = 1'b0;
  logic       reseteo = 1'b0;
  logic       tick_1s = 1'b0;
  logic       mon_1 = 1'b0, mon_2 = 1'b0, mon_5 = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       comprar = 1'b0, cancelar = 1'b0;
  logic [5:0] credito, cambio;
  logic [3:0] dispensa;
  logic       rechazo, insuf;
  logic [1:0] estado;

  typedef struct {
    string tag;
    int    cred;
    int    camb;
    int    disp;
    int    rech;
    int    ins;
    int    est;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  dispensador_multi dut (
    .clock    (clock),
    .reseteo  (reseteo),
    .tick_1s  (tick_1s),
    .mon_1    (mon_1),
    .mon_2    (mon_2),
    .mon_5    (mon_5),
    .sel      (sel),
    .comprar  (comprar),
    .cancelar (cancelar),
    .credito  (credito),
    .cambio   (cambio),
    .dispensa (dispensa),
    .rechazo  (rechazo),
    .insuf    (insuf),
    .estado   (estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, compare after the edge.
  task automatic cyc(input logic [2:0] mon, input logic buy, input logic can, input logic tk,
                     input logic [1:0] s, input string tag,
                     input int cr, input int ca, input int di, input int re, input int in_v, input int es);
    exp_t e;
    {mon_5, mon_2, mon_1} = mon;
    comprar  = buy;
    cancelar = can;
    tick_1s  = tk;
    sel      = s;
    e.tag = tag; e.cred = cr; e.camb = ca; e.disp = di; e.rech = re; e.ins = in_v; e.est = es;
    sb.push_back(e);
    @(posedge clock);
    #1;
    {mon_5, mon_2, mon_1} = 3'b000;
    comprar  = 1'b0;
    cancelar = 1'b0;
    tick_1s  = 1'b0;
    e = sb.pop_front();
    check({e.tag, ".credito"},  32'(credito),  e.cred);
    check({e.tag, ".cambio"},   32'(cambio),   e.camb);
    check({e.tag, ".dispensa"}, 32'(dispensa), e.disp);
    check({e.tag, ".rechazo"},  32'(rechazo),  e.rech);
    check({e.tag, ".insuf"},    32'(insuf),    e.ins);
    check({e.tag, ".estado"},   32'(estado),   e.est);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, with a coin pulse that must be ignored
    reseteo = 1'b0;
    cyc(M5, 0, 0, 0, 0, "rst0", 0, 0, 0, 0, 0, 0);
    cyc(M5, 0, 0, 1, 0, "rst1", 0, 0, 0, 0, 0, 0);
    reseteo = 1'b1;
    cyc(N,  0, 0, 0, 0, "idle", 0, 0, 0, 0, 0, 0);
    cyc(N,  1, 0, 0, 0, "buy_idle", 0, 0, 0, 0, 0, 0);

    // Exact purchase of product 0 (price 12)
    cyc(M5, 0, 0, 0, 0, "ex_c1", 5, 0, 0, 0, 0, 1);
    cyc(M5, 0, 0, 0, 0, "ex_c2", 10, 0, 0, 0, 0, 1);
    cyc(M2, 0, 0, 0, 0, "ex_c3", 12, 0, 0, 0, 0, 1);
    cyc(N,  1, 0, 0, 0, "ex_buy", 0, 0, 1, 0, 0, 2);
    cyc(N,  0, 0, 1, 0, "ex_t1", 0, 0, 1, 0, 0, 2);
    cyc(N,  0, 0, 1, 0, "ex_t2", 0, 0, 0, 0, 0, 0);

    // Purchase of product 1 (price 9) with 15 -> change 6
    for (int i = 1; i <= 3; i++) cyc(M5, 0, 0, 0, 0, "ch_coin", 5 * i, 0, 0, 0, 0, 1);
    cyc(N,  1, 0, 0, 1, "ch_buy", 0, 6, 2, 0, 0, 2);
    cyc(N,  0, 0, 1, 1, "ch_t1", 0, 6, 2, 0, 0, 2);
    cyc(N,  0, 0, 1, 1, "ch_t2", 0, 6, 0, 0, 0, 3);
    cyc(M1, 0, 0, 0, 1, "ch_refused", 0, 6, 0, 1, 0, 3);
    for (int k = 1; k <= 6; k++) cyc(N, 0, 0, 1, 1, "ch_pay", 0, 6 - k, 0, 0, 0, (k == 6) ? 0 : 3);

    // Insufficient credit, coin priority, buy beats coin, cancel, reset drops change
    cyc(M5,      0, 0, 0, 0, "in_c", 5, 0, 0, 0, 0, 1);
    cyc(N,       1, 0, 0, 0, "in_buy", 5, 0, 0, 0, 1, 1);
    cyc(M5 | M1, 0, 0, 0, 0, "in_pri", 10, 0, 0, 1, 0, 1);
    cyc(M2,      1, 0, 0, 0, "in_buycoin", 10, 0, 0, 1, 1, 1);
    cyc(N,       0, 1, 0, 0, "in_cancel", 0, 10, 0, 0, 0, 3);
    reseteo = 1'b0;
    cyc(N,       0, 0, 1, 0, "in_rst", 0, 0, 0, 0, 0, 0);
    reseteo = 1'b1;
    cyc(N,       0, 0, 1, 0, "in_after", 0, 0, 0, 0, 0, 0);

    // Saturation at MAX_CRED = 45
    for (int i = 1; i <= 8; i++) cyc(M5, 0, 0, 0, 0, "sat_fill", 5 * i, 0, 0, 0, 0, 1);
    cyc(M2, 0, 0, 0, 0, "sat_42", 42, 0, 0, 0, 0, 1);
    cyc(M2, 0, 0, 0, 0, "sat_44", 44, 0, 0, 0, 0, 1);
    cyc(M2, 0, 0, 0, 0, "sat_refuse", 44, 0, 0, 1, 0, 1);
    cyc(M1, 0, 0, 0, 0, "sat_max", 45, 0, 0, 0, 0, 1);
    cyc(M1, 0, 0, 0, 0, "sat_over", 45, 0, 0, 1, 0, 1);
    cyc(N,  0, 1, 0, 0, "sat_cancel", 0, 45, 0, 0, 0, 3);
    reseteo = 1'b0;
    cyc(N,  0, 0, 0, 0, "sat_rst", 0, 0, 0, 0, 0, 0);
    reseteo = 1'b1;

    // Idle timeout; an insufficient buy restarts the idle count
    cyc(M5, 0, 0, 0, 0, "to_c1", 5, 0, 0, 0, 0, 1);
    cyc(M2, 0, 0, 0, 0, "to_c2", 7, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) cyc(N, 0, 0, 1, 0, "to_wait_a", 7, 0, 0, 0, 0, 1);
    cyc(N,  1, 0, 0, 0, "to_insuf", 7, 0, 0, 0, 1, 1);
    for (int k = 1; k <= 9; k++) cyc(N, 0, 0, 1, 0, "to_wait_b", 7, 0, 0, 0, 0, 1);
    cyc(N,  0, 0, 1, 0, "to_fire", 0, 7, 0, 0, 0, 3);
    for (int k = 1; k <= 7; k++) cyc(N, 0, 0, 1, 0, "to_pay", 0, 7 - k, 0, 0, 0, (k == 7) ? 0 : 3);

    // Cancel and buy in the same cycle: cancel wins, no dispense, no insuf
    cyc(M2, 0, 0, 0, 0, "cb_c1", 2, 0, 0, 0, 0, 1);
    cyc(M1, 0, 0, 0, 0, "cb_c2", 3, 0, 0, 0, 0, 1);
    cyc(N,  1, 1, 0, 3, "cb_both", 0, 3, 0, 0, 0, 3);
    for (int k = 1; k <= 3; k++) cyc(N, 0, 0, 1, 0, "cb_pay", 0, 3 - k, 0, 0, 0, (k == 3) ? 0 : 3);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
